deserializer: RTL and testbench

DESERIALIZER -- requirements
Module: deserializer

---
 rtl/deserializer.sv | 120 ++++++++++++
 tb/tb_deserializer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/deserializer.sv
// Serial-to-parallel converter, MSB first, left-aligned output word.
// Define DESERIALIZER_TIMEOUT_EN to flush partial words after TIMEOUT idle cycles.
module deserializer #(
  parameter int DATA_W  = 16,
  parameter int MOD_W   = $clog2(DATA_W),
  parameter int TIMEOUT = 4
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              ser_data_i,
  input  logic              ser_data_val_i,
  output logic [DATA_W-1:0] deser_data_o,
  output logic [MOD_W-1:0]  deser_data_mod_o,
  output logic              deser_data_val_o,
  output logic              busy_o
);

  if (DATA_W < 2) begin : g_bad_data_w
    $error("DATA_W must be at least 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  typedef enum logic {
    IDLE,
    COLLECT
  } state_t;

  state_t state, state_n;

  logic [MOD_W-1:0]  cnt, cnt_n;
  logic [DATA_W-1:0] word, word_n;
  logic [DATA_W-1:0] data_n;
  logic [MOD_W-1:0]  mod_n;
  logic              val_n;
  logic [MOD_W-1:0]  pos;
  logic              last;

`ifdef DESERIALIZER_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT + 1);
  logic [IW-1:0] idle, idle_n;
`endif

  // Bits are OR-ed straight into their final left-aligned slot,
  // so a flush needs no realignment.
  assign pos  = MOD_W'(DATA_W - 1) - cnt;
  assign last = (cnt == MOD_W'(DATA_W - 1));

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    word_n  = word;
    data_n  = deser_data_o;
    mod_n   = deser_data_mod_o;
    val_n   = 1'b0;
`ifdef DESERIALIZER_TIMEOUT_EN
    idle_n  = idle;
`endif
    if (ser_data_val_i) begin
`ifdef DESERIALIZER_TIMEOUT_EN
      idle_n = '0;
`endif
      word_n = word | ({{(DATA_W-1){1'b0}}, ser_data_i} << pos);
      if (last) begin
        data_n  = word_n;
        mod_n   = '0;
        val_n   = 1'b1;
        state_n = IDLE;
        cnt_n   = '0;
        word_n  = '0;
      end else begin
        state_n = COLLECT;
        cnt_n   = cnt + MOD_W'(1);
      end
    end
`ifdef DESERIALIZER_TIMEOUT_EN
    else if (state == COLLECT) begin
      if (idle == IW'(TIMEOUT - 1)) begin
        data_n  = word;
        mod_n   = cnt;
        val_n   = 1'b1;
        state_n = IDLE;
        cnt_n   = '0;
        word_n  = '0;
        idle_n  = '0;
      end else begin
        idle_n = idle + IW'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state            <= IDLE;
      cnt              <= '0;
      word             <= '0;
      deser_data_o     <= '0;
      deser_data_mod_o <= '0;
      deser_data_val_o <= 1'b0;
`ifdef DESERIALIZER_TIMEOUT_EN
      idle             <= '0;
`endif
    end else begin
      state            <= state_n;
      cnt              <= cnt_n;
      word             <= word_n;
      deser_data_o     <= data_n;
      deser_data_mod_o <= mod_n;
      deser_data_val_o <= val_n;
`ifdef DESERIALIZER_TIMEOUT_EN
      idle             <= idle_n;
`endif
    end
  end

  assign busy_o = (state == COLLECT);

endmodule

// File: tb/tb_deserializer.sv
// Scoreboard bench for deserializer: stimulus pushes expected pulses,
// a negedge monitor pops and compares data, mod and pulse cycle.
module tb_deserializer;

  logic        clk_i = 1'b0;
  logic        arst_i = 1'b1;
  logic        ser_data_i = 1'b0;
  logic        ser_data_val_i = 1'b0;
  logic [15:0] deser_data_o;
  logic [3:0]  deser_data_mod_o;
  logic        deser_data_val_o;
  logic        busy_o;

  deserializer #(
    .DATA_W (16),
    .TIMEOUT(4)
  ) dut (
    .clk_i           (clk_i),
    .arst_i          (arst_i),
    .ser_data_i      (ser_data_i),
    .ser_data_val_i  (ser_data_val_i),
    .deser_data_o    (deser_data_o),
    .deser_data_mod_o(deser_data_mod_o),
    .deser_data_val_o(deser_data_val_o),
    .busy_o          (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  m;
    logic [31:0] c;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   passed = 0;
  int   cyc = 0;

  always @(posedge clk_i) cyc++;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  always @(negedge clk_i) begin
    if (deser_data_val_o === 1'b1) begin
      exp_t e;
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_pulse: data %h mod %0d at cycle %0d",
                 deser_data_o, deser_data_mod_o, cyc);
      end else begin
        e = exp_q.pop_front();
        if (deser_data_o === e.d && deser_data_mod_o === e.m &&
            cyc == int'(e.c))
          passed++;
        else
          $display("FAIL pulse: data %h mod %0d cyc %0d, expected %h %0d %0d",
                   deser_data_o, deser_data_mod_o, cyc, e.d, e.m, e.c);
      end
    end
  end

  task automatic idle(input int n);
    ser_data_val_i = 1'b0;
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ser_data_val_i = 1'b1;
    ser_data_i     = b;
    @(posedge clk_i);
    #1;
    ser_data_val_i = 1'b0;
  endtask

  task automatic send_bits(input logic [15:0] w, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      send_bit(w[15-i]);
      if (gap > 0 && i < n - 1) idle(gap);
    end
  endtask

  task automatic expect_pulse(input logic [15:0] d, input logic [3:0] m);
    exp_q.push_back({d, m, 32'(cyc)});
  endtask

  initial begin
    int busy_drops;
    #3;
    chk("rst_data", 32'(deser_data_o), 32'h0);
    chk("rst_mod", 32'(deser_data_mod_o), 32'h0);
    chk("rst_val", 32'(deser_data_val_o), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    @(negedge clk_i);
    arst_i = 1'b0;
    @(posedge clk_i);
    #1;

    send_bits(16'hAAAA, 16, 0);
    expect_pulse(16'hAAAA, 4'd0);
    chk("aaaa_busy", 32'(busy_o), 32'h0);
    idle(3);
    chk("hold_data", 32'(deser_data_o), 32'hAAAA);

    send_bits(16'h1234, 16, 0);
    expect_pulse(16'h1234, 4'd0);
    send_bits(16'hFFFF, 16, 0);
    expect_pulse(16'hFFFF, 4'd0);
    idle(2);

`ifdef DESERIALIZER_TIMEOUT_EN
    send_bits(16'hB000, 5, 0);
    idle(3);
    chk("flush_busy_pre", 32'(busy_o), 32'h1);
    idle(1);
    expect_pulse(16'hB000, 4'd5);
    chk("flush_busy_post", 32'(busy_o), 32'h0);
    idle(2);

    send_bits(16'h5A5A, 16, 3);
    expect_pulse(16'h5A5A, 4'd0);
    idle(6);

    send_bits(16'hFFFF, 15, 0);
    idle(4);
    expect_pulse(16'hFFFE, 4'd15);
    send_bits(16'h8000, 1, 0);
    idle(4);
    expect_pulse(16'h8000, 4'd1);
    idle(2);
`else
    send_bits(16'hB3C5, 5, 0);
    busy_drops = 0;
    for (int i = 0; i < 100; i++) begin
      idle(1);
      if (busy_o !== 1'b1) busy_drops++;
    end
    chk("hold_busy_drops", 32'(busy_drops), 32'h0);
    send_bits(16'hB3C5 << 5, 11, 0);
    expect_pulse(16'hB3C5, 4'd0);
    idle(2);
`endif

    send_bits(16'hFFFF, 7, 0);
    #2;
    arst_i = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy_o), 32'h0);
    chk("mid_rst_data", 32'(deser_data_o), 32'h0);
    chk("mid_rst_val", 32'(deser_data_val_o), 32'h0);
    #1;
    arst_i = 1'b0;
    idle(3);
    send_bits(16'hC3C3, 16, 0);
    expect_pulse(16'hC3C3, 4'd0);
    chk("c3c3_busy", 32'(busy_o), 32'h0);
    idle(10);

    chk("pending_pulses", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
